mc_controller: RTL



---
 rtl/mc_controller_pkg.sv | 77 +++++++
 rtl/mc_controller_if.sv | 37 +++
 rtl/mc_controller_alu_decoder.sv | 29 ++
 rtl/mc_controller.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mc_controller_pkg.sv
// Shared types and constants for the multi-cycle MIPS main controller.
// States, opcode/funct fields, ALU codes and the datapath control bundle.
package mc_ctrl_pkg;

  localparam int OP_W    = 6;
  localparam int FUNCT_W = 6;
  localparam int ALU_W   = 3;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

  typedef logic [1:0] alu_op_t;
  localparam alu_op_t ALUOP_ADD   = 2'b00;
  localparam alu_op_t ALUOP_SUB   = 2'b01;
  localparam alu_op_t ALUOP_FUNCT = 2'b10;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Moore-decoded datapath controls; alu_cntrl/illegal_instr travel separately.
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iRwrite;
    logic       regWrite;
    logic       memWrite;
    logic       IorD;
    logic       regDst;
    logic       memToReg;
    logic       aluSrc_a;
    logic [1:0] aluSrc_b;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_supported_op(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction word in, control signals out.
// master = controller side, slave = datapath side.
interface mc_controller_if #(
  parameter int BUS_WIDTH = 32
);

  logic [BUS_WIDTH-1:0] instr;
  logic                 pc_write;
  logic                 branch;
  logic                 iRwrite;
  logic                 regWrite;
  logic                 memWrite;
  logic                 IorD;
  logic                 regDst;
  logic                 memToReg;
  logic                 aluSrc_a;
  logic [1:0]           aluSrc_b;
  logic [1:0]           pc_src;
  logic [2:0]           alu_cntrl;
  logic                 illegal_instr;
  logic [3:0]           state_dbg;

  modport master (
    input  instr,
    output pc_write, branch, iRwrite, regWrite, memWrite, IorD, regDst,
           memToReg, aluSrc_a, aluSrc_b, pc_src, alu_cntrl, illegal_instr,
           state_dbg
  );

  modport slave (
    output instr,
    input  pc_write, branch, iRwrite, regWrite, memWrite, IorD, regDst,
           memToReg, aluSrc_a, aluSrc_b, pc_src, alu_cntrl, illegal_instr,
           state_dbg
  );

endinterface

// File: rtl/mc_controller_alu_decoder.sv
// ALU operation decoder: ALUOp plus funct to the 3-bit ALU control code.
// Unknown funct values fall back to add so the instruction still completes.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_op_t            alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALU_W-1:0]   alu_cntrl
);

  always_comb begin
    alu_cntrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_cntrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alu_cntrl = ALU_ADD;
          F_SUB:   alu_cntrl = ALU_SUB;
          F_AND:   alu_cntrl = ALU_AND;
          F_OR:    alu_cntrl = ALU_OR;
          F_SLT:   alu_cntrl = ALU_SLT;
          default: alu_cntrl = ALU_ADD;
        endcase
      end
      default: alu_cntrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Main control unit of the multi-cycle MIPS core: Moore FSM plus ALU decoder.
// All outputs are forced low while rst is asserted, so an aborted instruction never strobes.
//
//   state    | meaning
//   FETCH    | read instruction at PC, PC <= PC + 4
//   DECODE   | read registers, precompute branch target, dispatch on opcode
//   MEMADR   | compute lw/sw effective address
//   MEMRD    | read data memory at aluOut
//   MEMWB    | write loaded word to rt
//   MEMWR    | write register B to memory at aluOut
//   EXECUTE  | R-type ALU operation
//   ALUWB    | write ALU result to rd
//   BRANCH   | compare A/B, load PC with branch target if equal
//   ADDIEXEC | A + sign-extended immediate
//   ADDIWB   | write addi result to rt
//   JUMP     | load PC with jump address
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int OP_WIDTH    = 6,
  parameter int FUNCT_WIDTH = 6,
  parameter int BUS_WIDTH   = 32
) (
  input  logic              clk,
  input  logic              rst,
  mc_controller_if.master   bus
);

  state_t                 state;
  state_t                 state_nxt;
  ctrl_t                  ctrl_d;
  ctrl_t                  ctrl_q;
  alu_op_t                alu_op;
  logic                   illegal_d;
  logic [ALU_W-1:0]       alu_cntrl_d;
  logic [OP_WIDTH-1:0]    opcode;
  logic [FUNCT_WIDTH-1:0] funct;
  logic                   unused_instr_bits;

  assign opcode            = bus.instr[BUS_WIDTH-1 -: OP_WIDTH];
  assign funct             = bus.instr[FUNCT_WIDTH-1:0];
  assign unused_instr_bits = ^bus.instr[BUS_WIDTH-OP_WIDTH-1:FUNCT_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    ctrl_d    = '0;
    alu_op    = ALUOP_ADD;
    illegal_d = 1'b0;
    state_nxt = FETCH;
    case (state)
      FETCH: begin
        ctrl_d.aluSrc_b = SRCB_FOUR;
        ctrl_d.iRwrite  = 1'b1;
        ctrl_d.pc_write = 1'b1;
        state_nxt       = DECODE;
      end
      DECODE: begin
        ctrl_d.aluSrc_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BRANCH;
          OP_ADDI:      state_nxt = ADDIEXEC;
          OP_J:         state_nxt = JUMP;
          default: begin
            state_nxt = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ctrl_d.aluSrc_a = 1'b1;
        ctrl_d.aluSrc_b = SRCB_IMM;
        // Anything but a store reads; a stray write is the costlier mistake.
        state_nxt       = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        ctrl_d.IorD = 1'b1;
        state_nxt   = MEMWB;
      end
      MEMWB: begin
        ctrl_d.memToReg = 1'b1;
        ctrl_d.regWrite = 1'b1;
        state_nxt       = FETCH;
      end
      MEMWR: begin
        ctrl_d.IorD     = 1'b1;
        ctrl_d.memWrite = 1'b1;
        state_nxt       = FETCH;
      end
      EXECUTE: begin
        ctrl_d.aluSrc_a = 1'b1;
        ctrl_d.aluSrc_b = SRCB_REG;
        alu_op          = ALUOP_FUNCT;
        state_nxt       = ALUWB;
      end
      ALUWB: begin
        ctrl_d.regDst   = 1'b1;
        ctrl_d.regWrite = 1'b1;
        state_nxt       = FETCH;
      end
      BRANCH: begin
        ctrl_d.aluSrc_a = 1'b1;
        ctrl_d.aluSrc_b = SRCB_REG;
        ctrl_d.pc_src   = PC_ALUOUT;
        ctrl_d.branch   = 1'b1;
        alu_op          = ALUOP_SUB;
        state_nxt       = FETCH;
      end
      ADDIEXEC: begin
        ctrl_d.aluSrc_a = 1'b1;
        ctrl_d.aluSrc_b = SRCB_IMM;
        state_nxt       = ADDIWB;
      end
      ADDIWB: begin
        ctrl_d.regWrite = 1'b1;
        state_nxt       = FETCH;
      end
      JUMP: begin
        ctrl_d.pc_src   = PC_JUMP;
        ctrl_d.pc_write = 1'b1;
        state_nxt       = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op    (alu_op),
    .funct     (funct),
    .alu_cntrl (alu_cntrl_d)
  );

  assign ctrl_q = rst ? ctrl_d : '0;

  assign bus.pc_write      = ctrl_q.pc_write;
  assign bus.branch        = ctrl_q.branch;
  assign bus.iRwrite       = ctrl_q.iRwrite;
  assign bus.regWrite      = ctrl_q.regWrite;
  assign bus.memWrite      = ctrl_q.memWrite;
  assign bus.IorD          = ctrl_q.IorD;
  assign bus.regDst        = ctrl_q.regDst;
  assign bus.memToReg      = ctrl_q.memToReg;
  assign bus.aluSrc_a      = ctrl_q.aluSrc_a;
  assign bus.aluSrc_b      = ctrl_q.aluSrc_b;
  assign bus.pc_src        = ctrl_q.pc_src;
  assign bus.alu_cntrl     = rst ? alu_cntrl_d : '0;
  assign bus.illegal_instr = rst & illegal_d;
  assign bus.state_dbg     = state;

endmodule
